// File: rtl/pc_pkg.sv
// Shared op encodings and width helpers for the program-counter unit.
package pc_pkg;

   localparam int unsigned PC_OP_W = 3;

   localparam logic [PC_OP_W-1:0] PC_NOP  = 3'd0;
   localparam logic [PC_OP_W-1:0] PC_INC  = 3'd1;
   localparam logic [PC_OP_W-1:0] PC_JMP  = 3'd2;
   localparam logic [PC_OP_W-1:0] PC_BRR  = 3'd3;
   localparam logic [PC_OP_W-1:0] PC_CALL = 3'd4;
   localparam logic [PC_OP_W-1:0] PC_RET  = 3'd5;

   // Bits needed to count 0..depth stack entries.
   function automatic int unsigned pc_depth_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to index depth storage slots (at least one).
   function automatic int unsigned pc_idx_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; callers guarantee push/pop are valid and exclusive.
module pc_ret_stack
   import pc_pkg::*;
#(
   parameter  int unsigned ADDR_W  = 8,
   parameter  int unsigned DEPTH   = 4,
   localparam int unsigned DEPTH_W = pc_depth_w(DEPTH),
   localparam int unsigned IDX_W   = pc_idx_w(DEPTH)
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               push,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  din,
   output logic [ADDR_W-1:0]  top,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty
);

   logic [DEPTH_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0]  mem_q [DEPTH];
   logic [ADDR_W-1:0]  mem_d [DEPTH];
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   top_idx;

   assign wr_idx  = IDX_W'(ptr_q);
   assign top_idx = (ptr_q == '0) ? '0 : IDX_W'(ptr_q - DEPTH_W'(1));

   // Next pointer and storage image.
   always_comb begin
      ptr_d = ptr_q;
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_idx] = din;
         ptr_d         = ptr_q + DEPTH_W'(1);
      end else if (pop) begin
         ptr_d = ptr_q - DEPTH_W'(1);
      end
   end

   // Stack pointer; reset empties the stack.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign top   = mem_q[top_idx];
   assign depth = ptr_q;
   assign full  = (ptr_q == DEPTH_W'(DEPTH));
   assign empty = (ptr_q == '0);

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch and hardware CALL/RET stack.
module pc_stack_unit
   import pc_pkg::*;
#(
   parameter  int unsigned ADDR_W    = 8,
   parameter  int unsigned OFF_W     = 8,
   parameter  int unsigned DEPTH     = 4,
   parameter  int unsigned RESET_VEC = 0,
   localparam int unsigned DEPTH_W   = pc_depth_w(DEPTH)
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [PC_OP_W-1:0] pc_op,
   input  logic               pc_stall,
   input  logic [ADDR_W-1:0]  pc_target,
   input  logic [OFF_W-1:0]   pc_offset,
   input  logic               err_clr,
   output logic [ADDR_W-1:0]  address,
   output logic [DEPTH_W-1:0] stack_depth,
   output logic               stack_empty,
   output logic               stack_full,
   output logic               ovf_err,
   output logic               unf_err
);

   logic [ADDR_W-1:0] address_q, address_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              push, pop;
   logic [ADDR_W-1:0] push_din;
   logic [ADDR_W-1:0] stk_top;
   logic [ADDR_W-1:0] off_ext;
   logic [ADDR_W-1:0] addr_inc;

   assign off_ext  = ADDR_W'($signed(pc_offset));
   assign addr_inc = address_q + ADDR_W'(1);

   pc_ret_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_stack (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .push    (push),
      .pop     (pop),
      .din     (push_din),
      .top     (stk_top),
      .depth   (stack_depth),
      .full    (stack_full),
      .empty   (stack_empty)
   );

   // Next-address mux, validity-gated stack strobes and sticky flags.
   always_comb begin
      address_d = address_q;
      push      = 1'b0;
      pop       = 1'b0;
      push_din  = addr_inc;
      ovf_d     = ovf_q & ~err_clr;
      unf_d     = unf_q & ~err_clr;
      if (!pc_stall) begin
         case (pc_op)
            PC_INC: address_d = addr_inc;
            PC_JMP: address_d = pc_target;
            PC_BRR: address_d = address_q + off_ext;
            PC_CALL: begin
               if (stack_full) begin
                  ovf_d = 1'b1;
               end else begin
                  push      = 1'b1;
                  address_d = pc_target;
               end
            end
            PC_RET: begin
               if (stack_empty) begin
                  unf_d = 1'b1;
               end else begin
                  pop       = 1'b1;
                  address_d = stk_top;
               end
            end
            default: ;
         endcase
      end
   end

   // PC and error flag registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         address_q <= ADDR_W'(RESET_VEC);
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         address_q <= address_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign address = address_q;
   assign ovf_err = ovf_q;
   assign unf_err = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit with a queue-based reference model.
module tb_pc_stack_unit;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 3;
   localparam int unsigned DEPTH = 4;

   logic          CLK;
   logic          RESET_N;
   logic [2:0]    pc_op;
   logic          pc_stall;
   logic [AW-1:0] pc_target;
   logic [7:0]    pc_offset;
   logic          err_clr;
   logic [AW-1:0] address;
   logic [DW-1:0] stack_depth;
   logic          stack_empty, stack_full, ovf_err, unf_err;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   // reference model
   logic [AW-1:0] m_addr;
   logic [AW-1:0] m_stk[$];
   bit            m_ovf, m_unf;

   pc_stack_unit #(.ADDR_W(8), .OFF_W(8), .DEPTH(4), .RESET_VEC(0)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .pc_op(pc_op), .pc_stall(pc_stall),
      .pc_target(pc_target), .pc_offset(pc_offset), .err_clr(err_clr),
      .address(address), .stack_depth(stack_depth), .stack_empty(stack_empty),
      .stack_full(stack_full), .ovf_err(ovf_err), .unf_err(unf_err)
   );

   initial CLK = 0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_addr = 8'h00;
      m_stk.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   // Apply one op for one cycle and advance the model after the edge.
   task automatic step(input logic [2:0] op, input logic [7:0] tgt = 8'h00,
                       input logic [7:0] off = 8'h00, input bit stall = 0,
                       input bit clr = 0);
      pc_op = op; pc_target = tgt; pc_offset = off; pc_stall = stall; err_clr = clr;
      @(posedge CLK);
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (!stall) begin
         case (op)
            3'd1: m_addr = 8'(int'(m_addr) + 1);
            3'd2: m_addr = tgt;
            3'd3: m_addr = 8'(int'(m_addr) + int'($signed(off)));
            3'd4: if (m_stk.size() == DEPTH) m_ovf = 1;
                  else begin m_stk.push_back(8'(int'(m_addr) + 1)); m_addr = tgt; end
            3'd5: if (m_stk.size() == 0) m_unf = 1;
                  else m_addr = m_stk.pop_back();
            default: ;
         endcase
      end
      @(negedge CLK);
      pc_op = 3'd0; pc_stall = 0; err_clr = 0;
   endtask

   // Per-cycle comparison against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         check("address", 32'(address), 32'(m_addr));
         check("depth", 32'(stack_depth), 32'(m_stk.size()));
         check("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
         check("full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
         check("ovf", 32'(ovf_err), 32'(m_ovf));
         check("unf", 32'(unf_err), 32'(m_unf));
      end
   end

   initial begin
      RESET_N = 0; pc_op = 0; pc_stall = 0; pc_target = 0; pc_offset = 0; err_clr = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("rst_addr", 32'(address), 32'h00);
      check("rst_empty", 32'(stack_empty), 32'h1);
      check("rst_full", 32'(stack_full), 32'h0);
      RESET_N = 1;
      chk_en = 1;

      // increment and stall
      repeat (3) step(3'd1);
      check("inc3", 32'(address), 32'h03);
      repeat (2) step(3'd1, 8'h00, 8'h00, 1);
      check("stall", 32'(address), 32'h03);

      // jump and wrap
      step(3'd2, 8'hFE);
      check("jmp", 32'(address), 32'hFE);
      step(3'd1); step(3'd1);
      check("wrap", 32'(address), 32'h00);

      // relative branches
      step(3'd2, 8'h10);
      step(3'd3, 8'h00, 8'hF0);
      check("brr_m16", 32'(address), 32'h00);
      step(3'd3, 8'h00, 8'h05);
      check("brr_p5", 32'(address), 32'h05);
      step(3'd2, 8'h02);
      step(3'd3, 8'h00, 8'hFD);
      check("brr_m3", 32'(address), 32'hFF);

      // reserved codes hold
      step(3'd6); step(3'd7);
      check("reserved", 32'(address), 32'hFF);

      // nested calls
      step(3'd2, 8'h10);
      step(3'd4, 8'h40);
      step(3'd4, 8'h80);
      check("nest_depth", 32'(stack_depth), 32'h2);
      step(3'd5);
      check("ret1", 32'(address), 32'h41);
      step(3'd5);
      check("ret2", 32'(address), 32'h11);
      check("ret2_empty", 32'(stack_empty), 32'h1);
      step(3'd5);
      check("unf_hold", 32'(address), 32'h11);
      check("unf_set", 32'(unf_err), 32'h1);
      step(3'd0, 8'h00, 8'h00, 0, 1);
      check("unf_clr", 32'(unf_err), 32'h0);

      // back-to-back CALL/RET
      step(3'd4, 8'h60);
      step(3'd5);
      check("b2b_ret", 32'(address), 32'h12);

      // fill and overflow
      step(3'd4, 8'h20); step(3'd4, 8'h30); step(3'd4, 8'h40); step(3'd4, 8'h50);
      check("full", 32'(stack_full), 32'h1);
      step(3'd4, 8'hAA);
      check("ovf_hold", 32'(address), 32'h50);
      check("ovf_set", 32'(ovf_err), 32'h1);
      check("ovf_depth", 32'(stack_depth), 32'h4);
      step(3'd4, 8'hAA, 8'h00, 1);   // stalled CALL at full: no flag change
      step(3'd0, 8'h00, 8'h00, 0, 1);
      check("ovf_clr", 32'(ovf_err), 32'h0);
      step(3'd4, 8'hAA);             // re-raise overflow
      step(3'd5);
      check("ret_after_full", 32'(address), 32'h41);

      // async reset during a CALL at depth 3
      pc_op = 3'd4; pc_target = 8'hCC;
      #2 RESET_N = 0;
      chk_en = 0;
      model_reset();
      #1;
      check("arst_addr", 32'(address), 32'h00);
      check("arst_depth", 32'(stack_depth), 32'h0);
      check("arst_ovf", 32'(ovf_err), 32'h0);
      check("arst_unf", 32'(unf_err), 32'h0);
      @(negedge CLK);
      pc_op = 3'd0;
      RESET_N = 1;
      chk_en = 1;

      // error wins over clear in the same cycle
      step(3'd5, 8'h00, 8'h00, 0, 1);
      check("err_wins", 32'(unf_err), 32'h1);
      step(3'd1);
      check("post_rst_inc", 32'(address), 32'h01);

      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
